// File: rtl/cache_mem_arbiter_pkg.sv
// Shared constants, state encodings and sizing helpers for the cache/memory arbiter.
package cache_mem_arbiter_pkg;

  localparam int WORD_W          = 32;
  localparam int DEF_LINE_WORDS  = 4;
  localparam int DEF_LINE_BITS   = WORD_W * DEF_LINE_WORDS;
  localparam int BYTES_PER_WORD  = WORD_W / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    RD_RESP = 3'd3,
    WR_ADDR = 3'd4,
    WR_DATA = 3'd5
  } arb_state_e;

  // Which cache a read burst belongs to; also the encoding of last_rd_grant.
  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } rd_id_e;

  // Width of a beat counter that indexes every word of a line.
  function automatic int cnt_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  // Number of byte-offset bits inside one cache line.
  function automatic int offset_width(input int words);
    return $clog2(words * BYTES_PER_WORD);
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_line_buffer.sv
// Line buffer for the arbiter: word-wise fill for refills, whole-line load for
// writeback capture, and a word read mux for streaming beats out.
module mem_line_buffer #(
  parameter int LINE_WORDS = 4,
  parameter int WORD_W     = 32,
  parameter int IDX_W      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fill_en,
  input  logic [IDX_W-1:0]             fill_idx,
  input  logic [WORD_W-1:0]            fill_word,
  input  logic                         load_en,
  input  logic [LINE_WORDS*WORD_W-1:0] load_line,
  input  logic [IDX_W-1:0]             rd_idx,
  output logic [LINE_WORDS*WORD_W-1:0] line,
  output logic [WORD_W-1:0]            rd_word
);

  logic [LINE_WORDS-1:0][WORD_W-1:0] words_q;

  // Whole-line capture wins over a word fill; the two never coincide in practice.
  always_ff @(posedge clk) begin
    if (rst) begin
      words_q <= '0;
    end else if (load_en) begin
      words_q <= load_line;
    end else if (fill_en) begin
      words_q[fill_idx] <= fill_word;
    end
  end

  assign line    = words_q;
  assign rd_word = words_q[rd_idx];

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one word-serial memory port between ICache refill, DCache refill and
// DCache writeback. Writebacks win outright; reads alternate between I and D.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int ADDR_W     = WORD_W,
  parameter int LINE_BITS  = WORD_W * LINE_WORDS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rd_req,
  input  logic [ADDR_W-1:0]    i_rd_addr,
  output logic                 i_rd_ready,
  output logic [LINE_BITS-1:0] i_rd_line,
  input  logic                 d_rd_req,
  input  logic [ADDR_W-1:0]    d_rd_addr,
  output logic                 d_rd_ready,
  output logic [LINE_BITS-1:0] d_rd_line,
  input  logic                 d_wr_req,
  input  logic [ADDR_W-1:0]    d_wr_addr,
  input  logic [LINE_BITS-1:0] d_wr_line,
  output logic                 d_wr_ack,
  output logic                 mem_rd_req,
  output logic [ADDR_W-1:0]    mem_rd_addr,
  input  logic                 mem_rd_rdy,
  input  logic                 mem_ret_valid,
  input  logic                 mem_ret_last,
  input  logic [WORD_W-1:0]    mem_ret_data,
  output logic                 mem_wr_req,
  output logic [ADDR_W-1:0]    mem_wr_addr,
  input  logic                 mem_wr_rdy,
  output logic                 mem_wr_data_valid,
  output logic [WORD_W-1:0]    mem_wr_data,
  output logic                 mem_wr_last,
  input  logic                 mem_wr_data_rdy
);

  localparam int                 CNT_W      = cnt_width(LINE_WORDS);
  localparam int                 OFFSET_W   = offset_width(LINE_WORDS);
  localparam logic [CNT_W-1:0]   LAST_IDX   = CNT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0]  ALIGN_MASK = ~(ADDR_W'((1 << OFFSET_W) - 1));

  arb_state_e          state;
  logic [CNT_W-1:0]    cnt;
  rd_id_e              last_rd_grant;
  rd_id_e              rd_id;
  logic [ADDR_W-1:0]   addr_q;

  logic                grant_wr;
  logic                grant_i;
  logic                grant_d;
  logic                fill_en;
  logic [LINE_BITS-1:0] line;
  logic [WORD_W-1:0]   beat_word;

  // Arbitration: writeback first so a dirty victim always reaches memory before
  // any refill; between reads, a lone requester wins, a tie goes to whoever was
  // not served last.
  always_comb begin
    grant_wr = 1'b0;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    if (state == IDLE) begin
      if (d_wr_req) begin
        grant_wr = 1'b1;
      end else if (i_rd_req && (!d_rd_req || last_rd_grant == REQ_D)) begin
        grant_i = 1'b1;
      end else if (d_rd_req) begin
        grant_d = 1'b1;
      end
    end
  end

  // Main sequencer: latches the granted request and walks the memory handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      last_rd_grant <= REQ_D;
      rd_id         <= REQ_I;
      addr_q        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_wr) begin
            addr_q <= d_wr_addr & ALIGN_MASK;
            state  <= WR_ADDR;
          end else if (grant_i) begin
            addr_q        <= i_rd_addr & ALIGN_MASK;
            rd_id         <= REQ_I;
            last_rd_grant <= REQ_I;
            state         <= RD_ADDR;
          end else if (grant_d) begin
            addr_q        <= d_rd_addr & ALIGN_MASK;
            rd_id         <= REQ_D;
            last_rd_grant <= REQ_D;
            state         <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (mem_rd_rdy) begin
            cnt   <= '0;
            state <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (mem_ret_valid) begin
            if (mem_ret_last || cnt == LAST_IDX) begin
              cnt   <= '0;
              state <= RD_RESP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RD_RESP: begin
          state <= IDLE;
        end
        WR_ADDR: begin
          if (mem_wr_rdy) begin
            cnt   <= '0;
            state <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (mem_wr_data_rdy) begin
            if (cnt == LAST_IDX) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign fill_en = (state == RD_DATA) && mem_ret_valid;

  mem_line_buffer #(
    .LINE_WORDS (LINE_WORDS),
    .WORD_W     (WORD_W),
    .IDX_W      (CNT_W)
  ) u_line_buffer (
    .clk       (clk),
    .rst       (rst),
    .fill_en   (fill_en),
    .fill_idx  (cnt),
    .fill_word (mem_ret_data),
    .load_en   (grant_wr),
    .load_line (d_wr_line),
    .rd_idx    (cnt),
    .line      (line),
    .rd_word   (beat_word)
  );

  assign i_rd_ready = (state == RD_RESP) && (rd_id == REQ_I);
  assign d_rd_ready = (state == RD_RESP) && (rd_id == REQ_D);
  assign i_rd_line  = line;
  assign d_rd_line  = line;
  assign d_wr_ack   = grant_wr;

  assign mem_rd_req        = (state == RD_ADDR);
  assign mem_rd_addr       = mem_rd_req ? addr_q : '0;
  assign mem_wr_req        = (state == WR_ADDR);
  assign mem_wr_addr       = mem_wr_req ? addr_q : '0;
  assign mem_wr_data_valid = (state == WR_DATA);
  assign mem_wr_data       = mem_wr_data_valid ? beat_word : '0;
  assign mem_wr_last       = mem_wr_data_valid && (cnt == LAST_IDX);

endmodule
